// File: rtl/simple_fpga_cvs_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : simple_fpga_cvs_pkg
// Description : Shared constants for the simple FPGA check-and-verify design.
// Revision    : 1.0 - initial release
// ============================================================================
package simple_fpga_cvs_pkg;

    localparam int OSC_HZ    = 300_000_000;
    // Output frequency times two, so 1.5 Hz stays an integer.
    localparam int OUT_HZ_X2 = 3;
    localparam int DEFAULT_HALF_PERIOD_CYCLES = OSC_HZ * 2 / (2 * OUT_HZ_X2);

    // Width of a counter that must reach n-1; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage : simple_fpga_cvs_pkg
`default_nettype wire

// File: rtl/simple_fpga_cvs_clk_divider.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : clk_divider
// Description : Toggles clk_out every HALF_PERIOD_CYCLES rising edges of clk.
// Revision    : 1.0 - initial release
// ============================================================================
module clk_divider
    import simple_fpga_cvs_pkg::*;
#(
    parameter int HALF_PERIOD_CYCLES = DEFAULT_HALF_PERIOD_CYCLES
) (
    input  logic clk,
    input  logic reset,
    output logic clk_out
);

    localparam int                c_CNT_W    = cnt_width(HALF_PERIOD_CYCLES);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(HALF_PERIOD_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

    logic [c_CNT_W-1:0] r_cnt;
    logic               r_clk_out;

    // Both flops come out of configuration at 0 (device default INIT value),
    // so the output is defined even if reset is never asserted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt     <= '0;
            r_clk_out <= 1'b0;
        end else if (r_cnt == c_CNT_LAST) begin
            r_cnt     <= '0;
            r_clk_out <= ~r_clk_out;
        end else begin
            r_cnt     <= r_cnt + c_CNT_ONE;
        end
    end

    assign clk_out = r_clk_out;

endmodule : clk_divider
`default_nettype wire

// File: rtl/simple_fpga_cvs_top.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : simple_fpga_cvs_top
// Description : Board-level logic checks plus a 1.5 Hz divided square wave.
// Revision    : 1.0 - initial release
// ============================================================================
module simple_fpga_cvs_top
    import simple_fpga_cvs_pkg::*;
#(
    parameter int HALF_PERIOD_CYCLES = DEFAULT_HALF_PERIOD_CYCLES
) (
    input  logic       osc_300_p,
    input  logic       osc_300_n,
    input  logic       reset,
    input  logic [4:0] in,
    output logic       in0_out,
    output logic       in0_and_in1_out,
    output logic       in0_or_in1_out,
    output logic       not_in2_out,
    output logic       clk_1point5hz
);

    logic w_clk;

`ifdef SYNTHESIS
    IBUFDS u_osc_ibufds (
        .I  (osc_300_p),
        .IB (osc_300_n),
        .O  (w_clk)
    );
`else
    assign w_clk = osc_300_p;
`endif

    // in[4:3] are reserved; the negative oscillator leg only feeds the buffer.
    logic w_unused;
    assign w_unused = &{1'b0, osc_300_n, in[4:3]};

    assign in0_out         = in[0];
    assign in0_and_in1_out = in[0] & in[1];
    assign in0_or_in1_out  = in[0] | in[1];
    assign not_in2_out     = ~in[2];

    clk_divider #(
        .HALF_PERIOD_CYCLES (HALF_PERIOD_CYCLES)
    ) u_clk_divider (
        .clk     (w_clk),
        .reset   (reset),
        .clk_out (clk_1point5hz)
    );

endmodule : simple_fpga_cvs_top
`default_nettype wire

// File: tb/tb_simple_fpga_cvs_top.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_simple_fpga_cvs_top
// Description : Directed self-checking bench for simple_fpga_cvs_top.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_simple_fpga_cvs_top;

    localparam int HPC = 4;

    logic       osc_p;
    logic       osc_n;
    logic       rst_in;
    logic [4:0] in_v;
    logic       o_in0;
    logic       o_and;
    logic       o_or;
    logic       o_not2;
    logic       o_div;

    int total = 0;
    int bad   = 0;

    simple_fpga_cvs_top #(
        .HALF_PERIOD_CYCLES (HPC)
    ) dut (
        .osc_300_p       (osc_p),
        .osc_300_n       (osc_n),
        .reset           (rst_in),
        .in              (in_v),
        .in0_out         (o_in0),
        .in0_and_in1_out (o_and),
        .in0_or_in1_out  (o_or),
        .not_in2_out     (o_not2),
        .clk_1point5hz   (o_div)
    );

    initial osc_p = 1'b0;
    always #1.667 osc_p = ~osc_p;
    assign osc_n = ~osc_p;

    task automatic check(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Drive in, wait 1 ps, and compare all four logic outputs to hand values.
    task automatic apply_in(input logic [4:0] v, input logic e0, input logic ea,
                            input logic eo, input logic en, input string tag);
        in_v = v;
        #0.001;
        check({tag, ".in0"}, o_in0, e0);
        check({tag, ".and"}, o_and, ea);
        check({tag, ".or"},  o_or,  eo);
        check({tag, ".not2"}, o_not2, en);
    endtask

    initial begin
        int highs;
        logic exp_div;
        rst_in = 1'b1;
        in_v   = 5'b00000;

        // Logic outputs while reset is held
        apply_in(5'b00000, 1'b0, 1'b0, 1'b0, 1'b1, "rst_in00000");
        apply_in(5'b00011, 1'b1, 1'b1, 1'b1, 1'b1, "rst_in00011");
        apply_in(5'b00110, 1'b0, 1'b0, 1'b1, 1'b0, "rst_in00110");
        repeat (3) @(posedge osc_p);
        #1;
        check("div_in_reset", o_div, 1'b0);

        // in[0] pass-through
        apply_in(5'b00000, 1'b0, 1'b0, 1'b0, 1'b1, "in0_lo");
        apply_in(5'b00001, 1'b1, 1'b0, 1'b1, 1'b1, "in0_hi");
        apply_in(5'b00000, 1'b0, 1'b0, 1'b0, 1'b1, "in0_back");

        // (in1,in0) sweep
        apply_in(5'b00000, 1'b0, 1'b0, 1'b0, 1'b1, "sw00");
        apply_in(5'b00001, 1'b1, 1'b0, 1'b1, 1'b1, "sw01");
        apply_in(5'b00010, 1'b0, 1'b0, 1'b1, 1'b1, "sw10");
        apply_in(5'b00011, 1'b1, 1'b1, 1'b1, 1'b1, "sw11");

        // in[2] inversion and reserved bits
        apply_in(5'b00000, 1'b0, 1'b0, 1'b0, 1'b1, "in2_lo");
        apply_in(5'b00100, 1'b0, 1'b0, 1'b0, 1'b0, "in2_hi");
        apply_in(5'b11100, 1'b0, 1'b0, 1'b0, 1'b0, "rsv_hi_a");
        apply_in(5'b01011, 1'b1, 1'b1, 1'b1, 1'b1, "rsv_hi_b");
        apply_in(5'b10001, 1'b1, 1'b0, 1'b1, 1'b1, "rsv_hi_c");

        // Release reset between edges; output toggles every HPC edges
        @(negedge osc_p);
        rst_in = 1'b0;
        highs = 0;
        for (int k = 1; k <= 100; k++) begin
            @(posedge osc_p);
            #0.5;
            exp_div = ((k / HPC) % 2) == 1;
            check($sformatf("div_edge%0d", k), o_div, exp_div);
            if (k <= 96 && o_div === 1'b1) highs++;
        end
        total++;
        assert (highs == 48)
        else begin
            bad++;
            $error("FAIL duty_high_count: observed=%0d expected=%0d", highs, 48);
        end

        // Async reset mid-high-phase
        @(negedge osc_p);
        rst_in = 1'b1;
        @(negedge osc_p);
        rst_in = 1'b0;
        repeat (5) @(posedge osc_p);
        #0.5;
        check("pre_async_high", o_div, 1'b1);
        rst_in = 1'b1;
        #0.001;
        check("async_drop", o_div, 1'b0);
        @(posedge osc_p);
        #0.5;
        check("async_hold", o_div, 1'b0);
        @(negedge osc_p);
        rst_in = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            @(posedge osc_p);
            #0.5;
            exp_div = ((k / HPC) % 2) == 1;
            check($sformatf("restart_edge%0d", k), o_div, exp_div);
        end

        // Logic outputs unaffected by the running divider
        apply_in(5'b00101, 1'b1, 1'b0, 1'b1, 1'b0, "run_in00101");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_simple_fpga_cvs_top
`default_nettype wire
